// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
package btb_pkg;

  localparam int unsigned CTR_W = 2;

  typedef logic [CTR_W-1:0] ctr_t;

  localparam ctr_t STRONG_NOT_TAKEN = 2'b00;
  localparam ctr_t WEAK_NOT_TAKEN   = 2'b01;
  localparam ctr_t WEAK_TAKEN       = 2'b10;
  localparam ctr_t STRONG_TAKEN     = 2'b11;

  // Saturating 2-bit direction counter step.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t r;
    r = c;
    if (taken) begin
      if (c != STRONG_TAKEN) r = ctr_t'(c + 2'd1);
    end else begin
      if (c != STRONG_NOT_TAKEN) r = ctr_t'(c - 2'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Lookup / prediction / training / flush bundle of the BTB.
interface btb_assoc_if #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned NUM_WAYS = 2
);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);

  logic              flush;
  logic              lkp_valid;
  logic [ADDR_W-1:0] lkp_pc;
  logic              pred_valid;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic [WAY_W-1:0]  pred_way;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;

  modport master (
    output flush, lkp_valid, lkp_pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_valid, pred_taken, pred_target, pred_way
  );

  modport slave (
    input  flush, lkp_valid, lkp_pc, upd_valid, upd_pc, upd_taken, upd_target,
    output pred_valid, pred_taken, pred_target, pred_way
  );
endinterface

// File: rtl/btb_lru.sv
// True-LRU age tracking per set: two ordered touch ports (b applied after a)
// and victim selection (lowest invalid way, else the oldest way).
module btb_lru #(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned NUM_WAYS = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        touch_a_en,
  input  logic [$clog2(NUM_SETS)-1:0] touch_a_set,
  input  logic [$clog2(NUM_WAYS)-1:0] touch_a_way,
  input  logic                        touch_b_en,
  input  logic [$clog2(NUM_SETS)-1:0] touch_b_set,
  input  logic [$clog2(NUM_WAYS)-1:0] touch_b_way,
  input  logic [$clog2(NUM_SETS)-1:0] vic_set,
  input  logic [NUM_WAYS-1:0]         vic_valid,
  output logic [$clog2(NUM_WAYS)-1:0] victim_c
);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);

  typedef logic [NUM_WAYS-1:0][WAY_W-1:0] ages_t;

  ages_t age_q [NUM_SETS];
  ages_t age_d [NUM_SETS];

  // Make way w MRU; ways younger than w's old age each get one step older.
  function automatic ages_t touch(input ages_t a, input logic [WAY_W-1:0] w);
    ages_t r;
    r = a;
    for (int v = 0; v < int'(NUM_WAYS); v++) begin
      if (a[v] < a[w]) r[v] = WAY_W'(a[v] + 1'b1);
    end
    r[w] = '0;
    return r;
  endfunction

  // Apply lookup touch, then update touch, so the update ends up MRU.
  always_comb begin
    age_d = age_q;
    if (touch_a_en) age_d[touch_a_set] = touch(age_d[touch_a_set], touch_a_way);
    if (touch_b_en) age_d[touch_b_set] = touch(age_d[touch_b_set], touch_b_way);
  end

  // Age registers; way w starts with age w.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(NUM_SETS); s++)
        for (int w = 0; w < int'(NUM_WAYS); w++)
          age_q[s][w] <= WAY_W'(w);
    end else begin
      for (int s = 0; s < int'(NUM_SETS); s++)
        age_q[s] <= age_d[s];
    end
  end

  // Victim: lowest invalid way, otherwise the way holding the oldest age.
  always_comb begin
    logic found;
    found    = 1'b0;
    victim_c = '0;
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      if (!found && !vic_valid[w]) begin
        victim_c = WAY_W'(w);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < int'(NUM_WAYS); w++)
        if (age_q[vic_set][w] == WAY_W'(NUM_WAYS - 1)) victim_c = WAY_W'(w);
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer with registered lookup and
// edge-applied training. Optional macro BTB_UPDATE_BYPASS_EN forwards a
// same-cycle update that matches the lookup's set and tag.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned NUM_WAYS = 2,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  btb_assoc_if.slave    bus
);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    ctr_t              ctr;
  } entry_t;

  entry_t mem [NUM_SETS][NUM_WAYS];

  logic [IDX_W-1:0] lkp_idx, upd_idx;
  logic [TAG_W-1:0] lkp_tag, upd_tag;
  logic             lkp_hit, upd_hit, upd_write;
  logic [WAY_W-1:0] lkp_way, upd_hit_way, upd_way, victim_c;
  logic [NUM_WAYS-1:0] upd_set_valid;
  ctr_t             upd_ctr;
  logic             pred_hit_c, pred_taken_c;
  logic [ADDR_W-1:0] pred_target_c;
  logic [WAY_W-1:0] pred_way_c;
  logic             unused_pc_bits;

  assign lkp_idx = bus.lkp_pc[IDX_W+1:2];
  assign lkp_tag = bus.lkp_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = bus.upd_pc[IDX_W+1:2];
  assign upd_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_bits = ^{bus.lkp_pc[1:0], bus.upd_pc[1:0]};

  // Tag match for both ports; descending scan so the lowest way wins.
  always_comb begin
    lkp_hit     = 1'b0;
    lkp_way     = '0;
    upd_hit     = 1'b0;
    upd_hit_way = '0;
    for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
      upd_set_valid[w] = mem[upd_idx][w].valid;
      if (mem[lkp_idx][w].valid && mem[lkp_idx][w].tag == lkp_tag) begin
        lkp_hit = 1'b1;
        lkp_way = WAY_W'(w);
      end
      if (mem[upd_idx][w].valid && mem[upd_idx][w].tag == upd_tag) begin
        upd_hit     = 1'b1;
        upd_hit_way = WAY_W'(w);
      end
    end
  end

  // Training decision: hit trains the counter, taken miss allocates.
  always_comb begin
    upd_way   = upd_hit ? upd_hit_way : victim_c;
    upd_write = bus.upd_valid && !bus.flush && (upd_hit || bus.upd_taken);
    upd_ctr   = upd_hit ? ctr_next(mem[upd_idx][upd_hit_way].ctr, bus.upd_taken)
                        : WEAK_TAKEN;
  end

  btb_lru #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_lru (
    .clk         (clk),
    .rst_n       (rst_n),
    .touch_a_en  (bus.lkp_valid && lkp_hit && !bus.flush),
    .touch_a_set (lkp_idx),
    .touch_a_way (lkp_way),
    .touch_b_en  (upd_write),
    .touch_b_set (upd_idx),
    .touch_b_way (upd_way),
    .vic_set     (upd_idx),
    .vic_valid   (upd_set_valid),
    .victim_c    (victim_c)
  );

  // Entry array: flush clears valid bits and drops any concurrent update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(NUM_SETS); s++)
        for (int w = 0; w < int'(NUM_WAYS); w++)
          mem[s][w] <= '{valid: 1'b0, tag: '0, target: '0, ctr: STRONG_NOT_TAKEN};
    end else if (bus.flush) begin
      for (int s = 0; s < int'(NUM_SETS); s++)
        for (int w = 0; w < int'(NUM_WAYS); w++)
          mem[s][w].valid <= 1'b0;
    end else if (upd_write) begin
      mem[upd_idx][upd_way].valid <= 1'b1;
      mem[upd_idx][upd_way].tag   <= upd_tag;
      mem[upd_idx][upd_way].ctr   <= upd_ctr;
      if (bus.upd_taken) mem[upd_idx][upd_way].target <= bus.upd_target;
    end
  end

  // Next prediction from pre-update contents, optionally forwarding the update.
  always_comb begin
    pred_hit_c    = lkp_hit && !bus.flush;
    pred_taken_c  = pred_hit_c && mem[lkp_idx][lkp_way].ctr[1];
    pred_target_c = pred_hit_c ? mem[lkp_idx][lkp_way].target : '0;
    pred_way_c    = pred_hit_c ? lkp_way : '0;
`ifdef BTB_UPDATE_BYPASS_EN
    if (upd_write && upd_idx == lkp_idx && upd_tag == lkp_tag) begin
      pred_hit_c    = 1'b1;
      pred_taken_c  = upd_ctr[1];
      pred_target_c = bus.upd_taken ? bus.upd_target : mem[upd_idx][upd_way].target;
      pred_way_c    = upd_way;
    end
`endif
  end

  // Prediction registers, loaded on each lookup and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pred_valid  <= 1'b0;
      bus.pred_taken  <= 1'b0;
      bus.pred_target <= '0;
      bus.pred_way    <= '0;
    end else if (bus.lkp_valid) begin
      bus.pred_valid  <= pred_hit_c;
      bus.pred_taken  <= pred_taken_c;
      bus.pred_target <= pred_target_c;
      bus.pred_way    <= pred_way_c;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed self-checking bench for btb_assoc at default parameters.
// Expectations for same-cycle lookup+allocate follow BTB_UPDATE_BYPASS_EN.
module tb_btb_assoc;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  btb_assoc_if #(.ADDR_W(32), .NUM_WAYS(2)) bus ();

  btb_assoc #(
    .NUM_SETS (8),
    .NUM_WAYS (2),
    .ADDR_W   (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_taken  = tk;
    bus.upd_target = tgt;
    tick();
    bus.upd_valid  = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    bus.lkp_valid = 1'b1;
    bus.lkp_pc    = pc;
    tick();
    bus.lkp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.flush      = 1'b0;
    bus.lkp_valid  = 1'b0;
    bus.lkp_pc     = '0;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_taken  = 1'b0;
    bus.upd_target = '0;
    #12;
    checks++;
    if ({bus.pred_valid, bus.pred_taken, bus.pred_target, bus.pred_way} !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {bus.pred_valid, bus.pred_taken, bus.pred_target, bus.pred_way});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_lookup(32'h0000_1000);
    checks++;
    if (bus.pred_valid !== 1'b0) begin failures++; $display("FAIL reset_lkp_valid got=%b exp=0", bus.pred_valid); end
    checks++;
    if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL reset_lkp_taken got=%b exp=0", bus.pred_taken); end
    checks++;
    if (bus.pred_target !== 32'h0) begin failures++; $display("FAIL reset_lkp_target got=%h exp=0", bus.pred_target); end
  endtask

  task automatic test_lru();
    do_update(32'h000, 1'b1, 32'h100);
    do_update(32'h020, 1'b1, 32'h200);
    do_lookup(32'h000);
    checks++;
    if (bus.pred_valid !== 1'b1 || bus.pred_way !== 1'b0 || bus.pred_target !== 32'h100) begin
      failures++;
      $display("FAIL lru_hit000 got=%b/%b/%h exp=1/0/100", bus.pred_valid, bus.pred_way, bus.pred_target);
    end
    do_lookup(32'h020);
    checks++;
    if (bus.pred_valid !== 1'b1 || bus.pred_way !== 1'b1 || bus.pred_target !== 32'h200) begin
      failures++;
      $display("FAIL lru_hit020 got=%b/%b/%h exp=1/1/200", bus.pred_valid, bus.pred_way, bus.pred_target);
    end
    do_lookup(32'h000);
    do_update(32'h040, 1'b1, 32'h300);
    do_lookup(32'h020);
    checks++;
    if (bus.pred_valid !== 1'b0) begin failures++; $display("FAIL lru_evicted020 got=%b exp=0", bus.pred_valid); end
    do_lookup(32'h000);
    checks++;
    if (bus.pred_valid !== 1'b1 || bus.pred_target !== 32'h100) begin
      failures++;
      $display("FAIL lru_kept000 got=%b/%h exp=1/100", bus.pred_valid, bus.pred_target);
    end
    do_lookup(32'h040);
    checks++;
    if (bus.pred_valid !== 1'b1 || bus.pred_way !== 1'b1 || bus.pred_target !== 32'h300) begin
      failures++;
      $display("FAIL lru_new040 got=%b/%b/%h exp=1/1/300", bus.pred_valid, bus.pred_way, bus.pred_target);
    end
  endtask

  task automatic test_train();
    do_update(32'h1000, 1'b1, 32'h2000);
    do_lookup(32'h1000);
    checks++;
    if (bus.pred_valid !== 1'b1 || bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h2000) begin
      failures++;
      $display("FAIL train_alloc got=%b/%b/%h exp=1/1/2000", bus.pred_valid, bus.pred_taken, bus.pred_target);
    end
    do_update(32'h1000, 1'b0, 32'h9999);
    do_update(32'h1000, 1'b0, 32'h9999);
    do_lookup(32'h1000);
    checks++;
    if (bus.pred_valid !== 1'b1 || bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h2000) begin
      failures++;
      $display("FAIL train_nt got=%b/%b/%h exp=1/0/2000", bus.pred_valid, bus.pred_taken, bus.pred_target);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) do_update(32'h0104, 1'b1, 32'h5000);
    do_lookup(32'h0104);
    checks++;
    if (bus.pred_valid !== 1'b1 || bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h5000) begin
      failures++;
      $display("FAIL sat_taken got=%b/%b/%h exp=1/1/5000", bus.pred_valid, bus.pred_taken, bus.pred_target);
    end
    do_update(32'h0104, 1'b0, 32'h0);
    do_lookup(32'h0104);
    checks++;
    if (bus.pred_taken !== 1'b1) begin failures++; $display("FAIL sat_one_nt got=%b exp=1", bus.pred_taken); end
    do_update(32'h0104, 1'b0, 32'h0);
    do_lookup(32'h0104);
    checks++;
    if (bus.pred_valid !== 1'b1 || bus.pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL sat_two_nt got=%b/%b exp=1/0", bus.pred_valid, bus.pred_taken);
    end
  endtask

  task automatic test_flush();
    logic [31:0] pcs [4];
    pcs[0] = 32'h0208;
    pcs[1] = 32'h020C;
    pcs[2] = 32'h0210;
    pcs[3] = 32'h0214;
    for (int i = 0; i < 3; i++) do_update(pcs[i], 1'b1, 32'h7000 + 32'(i));
    do_lookup(pcs[2]);
    checks++;
    if (bus.pred_valid !== 1'b1 || bus.pred_target !== 32'h7002) begin
      failures++;
      $display("FAIL flush_pre got=%b/%h exp=1/7002", bus.pred_valid, bus.pred_target);
    end
    bus.flush      = 1'b1;
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pcs[3];
    bus.upd_taken  = 1'b1;
    bus.upd_target = 32'h7777;
    bus.lkp_valid  = 1'b1;
    bus.lkp_pc     = pcs[0];
    tick();
    bus.flush     = 1'b0;
    bus.upd_valid = 1'b0;
    bus.lkp_valid = 1'b0;
    checks++;
    if (bus.pred_valid !== 1'b0) begin failures++; $display("FAIL flush_same_cycle_lkp got=%b exp=0", bus.pred_valid); end
    for (int i = 0; i < 4; i++) begin
      do_lookup(pcs[i]);
      checks++;
      if (bus.pred_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_miss_%0d got=%b exp=0", i, bus.pred_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_update(32'h0300, 1'b1, 32'h3000);
    do_update(32'h0304, 1'b1, 32'h3004);
    bus.lkp_valid = 1'b1;
    bus.lkp_pc    = 32'h0300;
    tick();
    checks++;
    if (bus.pred_valid !== 1'b1 || bus.pred_target !== 32'h3000) begin
      failures++;
      $display("FAIL b2b_0 got=%b/%h exp=1/3000", bus.pred_valid, bus.pred_target);
    end
    bus.lkp_pc = 32'h0304;
    tick();
    checks++;
    if (bus.pred_valid !== 1'b1 || bus.pred_target !== 32'h3004) begin
      failures++;
      $display("FAIL b2b_1 got=%b/%h exp=1/3004", bus.pred_valid, bus.pred_target);
    end
    bus.lkp_pc = 32'h0308;
    tick();
    checks++;
    if (bus.pred_valid !== 1'b0 || bus.pred_target !== 32'h0) begin
      failures++;
      $display("FAIL b2b_2 got=%b/%h exp=0/0", bus.pred_valid, bus.pred_target);
    end
    bus.lkp_pc = 32'h0304;
    tick();
    bus.lkp_valid = 1'b0;
    bus.lkp_pc    = 32'h0308;
    tick();
    tick();
    checks++;
    if (bus.pred_valid !== 1'b1 || bus.pred_target !== 32'h3004) begin
      failures++;
      $display("FAIL b2b_hold got=%b/%h exp=1/3004", bus.pred_valid, bus.pred_target);
    end
  endtask

  task automatic test_same_cycle();
    logic       exp_v;
    logic [31:0] exp_t;
`ifdef BTB_UPDATE_BYPASS_EN
    exp_v = 1'b1;
    exp_t = 32'h4400;
`else
    exp_v = 1'b0;
    exp_t = 32'h0;
`endif
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 32'h0400;
    bus.upd_taken  = 1'b1;
    bus.upd_target = 32'h4400;
    bus.lkp_valid  = 1'b1;
    bus.lkp_pc     = 32'h0400;
    tick();
    bus.upd_valid = 1'b0;
    bus.lkp_valid = 1'b0;
    checks++;
    if (bus.pred_valid !== exp_v || bus.pred_target !== exp_t || bus.pred_taken !== exp_v) begin
      failures++;
      $display("FAIL same_cycle got=%b/%b/%h exp=%b/%b/%h", bus.pred_valid, bus.pred_taken, bus.pred_target, exp_v, exp_v, exp_t);
    end
    do_lookup(32'h0400);
    checks++;
    if (bus.pred_valid !== 1'b1 || bus.pred_target !== 32'h4400) begin
      failures++;
      $display("FAIL same_cycle_after got=%b/%h exp=1/4400", bus.pred_valid, bus.pred_target);
    end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pred_valid !== 1'b0 || bus.pred_target !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset_async got=%b/%h exp=0/0", bus.pred_valid, bus.pred_target);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_lookup(32'h0400);
    checks++;
    if (bus.pred_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_cleared got=%b exp=0", bus.pred_valid); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_lru();
    test_train();
    test_saturate();
    test_flush();
    test_back_to_back();
    test_same_cycle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
